fetch_control: RTL and testbench

FETCH_CONTROL -- requirements
Module: fetch_control

---
 rtl/fetch_control.sv | 210 +++++++++++++++++++++
 tb/tb_fetch_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// rtl/fetch_control.sv - Y86-64 style fetch PC selection, hazard control and halt sequencing
//
// Purpose: selects the fetch address, predicts the next PC, classifies the
// fetched instruction's status, generates the pipeline stall/bubble controls
// for load-use, ret and mispredicted-jump hazards, and sequences processor
// halt through a RUN/DRAIN/HALTED state machine.
//
// Optional feature macro: FETCH_PERF_EN enables the cycle and stall
// performance counters; when undefined both counter ports read constant 0.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   f_icode, imem_error        fetched instruction code / fetch address error
//   f_valC, f_valP             immediate / incremented PC of fetched instruction
//   D/E/M/W_icode              instruction codes held in each later stage
//   d_srcA, d_srcB, E_dstM     decode sources, execute-stage load destination
//   e_Cnd, M_Cnd, M_valA       branch outcome and fall-through PC
//   W_valM                     return address of a ret in write-back
//   m_stat, W_stat             status in memory / write-back
//   f_pc, f_stat               fetch address and fetched instruction status
//   F_stall .. W_stall         pipeline register controls
//   halted, halt_stat          processor stopped and the status that stopped it
//   cycle_count, stall_count   performance counters

module fetch_control #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  f_icode,
    input  logic        imem_error,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  W_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [63:0] W_valM,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    output logic [63:0] f_pc,
    output logic [2:0]  f_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        halted,
    output logic [2:0]  halt_stat,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;
    logic [2:0]  halt_stat_q, halt_stat_d;

    logic load_use;
    logic ret_pending;
    logic mispredict;
    logic m_redirect;
    logic is_halted;

    always_comb begin
        load_use    = (E_icode == I_MRMOV || E_icode == I_POP) && (E_dstM != R_NONE)
                      && (E_dstM == d_srcA || E_dstM == d_srcB);
        ret_pending = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispredict  = (E_icode == I_JXX) && !e_Cnd;
        m_redirect  = (M_icode == I_JXX) && !M_Cnd;
        is_halted   = (state_q == ST_HALTED);
    end

    // Redirect sources override the prediction even while fetch is stalled,
    // so a stall never hides a correction arriving from M or W.
    always_comb begin
        if (m_redirect) begin
            f_pc = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc = W_valM;
        end else begin
            f_pc = pred_pc_q;
        end
    end

    always_comb begin
        if (imem_error) begin
            f_stat = S_ADR;
        end else if (f_icode > I_POP) begin
            f_stat = S_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = S_HLT;
        end else begin
            f_stat = S_AOK;
        end
    end

    // Once halted, nothing new may be injected, so D/E bubbles are suppressed.
    always_comb begin
        F_stall  = load_use || ret_pending || (state_q != ST_RUN);
        D_stall  = load_use;
        D_bubble = !is_halted && (mispredict || (ret_pending && !load_use));
        E_bubble = !is_halted && (mispredict || load_use);
        M_bubble = (m_stat != S_AOK) || (W_stat != S_AOK);
        W_stall  = (W_stat != S_AOK) || is_halted;
        halted   = is_halted;
        halt_stat = halt_stat_q;
    end

    always_comb begin
        state_d     = state_q;
        halt_stat_d = halt_stat_q;
        pred_pc_d   = pred_pc_q;
        if (!F_stall) begin
            pred_pc_d = (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;
        end
        case (state_q)
            ST_RUN: begin
                if (W_stat != S_AOK) begin
                    state_d     = ST_HALTED;
                    halt_stat_d = W_stat;
                end else if (f_stat != S_AOK && !F_stall && !D_bubble) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (W_stat != S_AOK) begin
                    state_d     = ST_HALTED;
                    halt_stat_d = W_stat;
                end else if (m_redirect) begin
                    // The faulting instruction was on a mispredicted path.
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pred_pc_q   <= RESET_PC;
            halt_stat_q <= S_AOK;
        end else begin
            state_q     <= state_d;
            pred_pc_q   <= pred_pc_d;
            halt_stat_q <= halt_stat_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        stall_count_d = stall_count_q;
        if (!is_halted && cycle_count_q != 32'hFFFF_FFFF) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (state_q == ST_RUN && F_stall && stall_count_q != 32'hFFFF_FFFF) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign stall_count = stall_count_q;
`else
    assign cycle_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// tb/tb_fetch_control.sv - self-checking bench for fetch_control

module tb_fetch_control;

`ifdef FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  f_icode;
    logic        imem_error;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  D_icode, E_icode, M_icode, W_icode;
    logic [3:0]  d_srcA, d_srcB, E_dstM;
    logic        e_Cnd, M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [2:0]  m_stat, W_stat;
    logic [63:0] f_pc;
    logic [2:0]  f_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic        halted;
    logic [2:0]  halt_stat;
    logic [31:0] cycle_count, stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_control #(.RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset), .f_icode(f_icode), .imem_error(imem_error),
        .f_valC(f_valC), .f_valP(f_valP), .D_icode(D_icode), .E_icode(E_icode),
        .M_icode(M_icode), .W_icode(W_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_Cnd(M_Cnd), .M_valA(M_valA),
        .W_valM(W_valM), .m_stat(m_stat), .W_stat(W_stat), .f_pc(f_pc),
        .f_stat(f_stat), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .halted(halted), .halt_stat(halt_stat), .cycle_count(cycle_count),
        .stall_count(stall_count)
    );

    // controls packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    function automatic logic [5:0] ctl();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
    endfunction

    task automatic idle_inputs();
        f_icode = 4'h1; imem_error = 1'b0; f_valC = 64'h0; f_valP = 64'h0;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_Cnd = 1'b1; M_valA = 64'h0; W_valM = 64'h0;
        m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; f_valP = 64'h2;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (f_pc !== 64'h0) $display("FAIL reset_f_pc got %h want 0", f_pc); else n_pass++;
        n_checks++; if (ctl() !== 6'b0) $display("FAIL reset_ctl got %b want 000000", ctl()); else n_pass++;
        n_checks++; if ({halted, halt_stat} !== 4'b0001) $display("FAIL reset_halt got %b/%0d want 0/1", halted, halt_stat); else n_pass++;
        n_checks++; if ({cycle_count, stall_count} !== 64'h0) $display("FAIL reset_counters got %0d/%0d want 0/0", cycle_count, stall_count); else n_pass++;
        tick(); #1;
        n_checks++; if (f_pc !== 64'h2) $display("FAIL seq_f_pc got %h want 2", f_pc); else n_pass++;
    endtask

    task automatic test_jump();
        do_reset();
        f_icode = 4'h7; f_valC = 64'h40;
        tick(); #1;
        n_checks++; if (f_pc !== 64'h40) $display("FAIL jump_pred got %h want 40", f_pc); else n_pass++;
        f_icode = 4'h1; f_valP = 64'h48; E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        n_checks++; if (ctl() !== 6'b001100) $display("FAIL mispredict_ctl got %b want 001100", ctl()); else n_pass++;
        tick();
        E_icode = 4'h1; M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h0A;
        #1;
        n_checks++; if (f_pc !== 64'h0A) $display("FAIL jump_redirect got %h want a", f_pc); else n_pass++;
    endtask

    task automatic test_load_use();
        logic [63:0] held;
        do_reset();
        f_valP = 64'h88;
        tick();
        held = 64'h88;
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; f_valP = 64'h99;
        #1;
        n_checks++; if (ctl() !== 6'b110100) $display("FAIL load_use_ctl got %b want 110100", ctl()); else n_pass++;
        tick(); #1;
        n_checks++; if (f_pc !== held) $display("FAIL load_use_hold got %h want %h", f_pc, held); else n_pass++;
        // stall together with a redirect: fetch shows the redirect, predPC holds
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h77;
        #1;
        n_checks++; if (f_pc !== 64'h77) $display("FAIL stall_redirect got %h want 77", f_pc); else n_pass++;
        tick();
        M_icode = 4'h1; E_icode = 4'h1;
        #1;
        n_checks++; if (f_pc !== held) $display("FAIL stall_redirect_hold got %h want %h", f_pc, held); else n_pass++;
    endtask

    task automatic test_ret();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            D_icode = (i == 0) ? 4'h9 : 4'h1;
            E_icode = (i == 1) ? 4'h9 : 4'h1;
            M_icode = (i == 2) ? 4'h9 : 4'h1;
            #1;
            n_checks++;
            if ({F_stall, D_bubble, E_bubble} !== 3'b110)
                $display("FAIL ret_stall_%0d got %b want 110", i, {F_stall, D_bubble, E_bubble});
            else n_pass++;
            tick();
        end
        M_icode = 4'h1; W_icode = 4'h9; W_valM = 64'h100;
        #1;
        n_checks++; if (f_pc !== 64'h100) $display("FAIL ret_target got %h want 100", f_pc); else n_pass++;
        n_checks++; if (F_stall !== 1'b0) $display("FAIL ret_release got %b want 0", F_stall); else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        f_icode = 4'h0;
        #1;
        n_checks++; if (f_stat !== 3'd2) $display("FAIL halt_fstat got %0d want 2", f_stat); else n_pass++;
        tick();
        f_icode = 4'h1;
        #1;
        n_checks++; if ({F_stall, halted} !== 2'b10) $display("FAIL drain_stall got %b want 10", {F_stall, halted}); else n_pass++;
        // a mispredicted jump reaching M cancels the drain
        M_icode = 4'h7; M_Cnd = 1'b0;
        tick();
        M_icode = 4'h1;
        #1;
        n_checks++; if (F_stall !== 1'b0) $display("FAIL drain_cancel got %b want 0", F_stall); else n_pass++;
        f_icode = 4'h0;
        tick();
        f_icode = 4'h1; W_stat = 3'd2;
        tick();
        W_stat = 3'd3; E_icode = 4'h7; e_Cnd = 1'b0;
        #1;
        n_checks++; if ({halted, halt_stat} !== 4'b1010) $display("FAIL halted got %b/%0d want 1/2", halted, halt_stat); else n_pass++;
        n_checks++; if (ctl() !== 6'b100011) $display("FAIL halted_ctl got %b want 100011", ctl()); else n_pass++;
        tick(); #1;
        n_checks++; if (halt_stat !== 3'd2) $display("FAIL halt_stat_frozen got %0d want 2", halt_stat); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0; idle_inputs();
        #1;
        n_checks++; if ({halted, halt_stat, F_stall} !== 5'b00010) $display("FAIL halt_reset got %b want 00010", {halted, halt_stat, F_stall}); else n_pass++;
        n_checks++; if (f_pc !== 64'h0) $display("FAIL halt_reset_pc got %h want 0", f_pc); else n_pass++;
    endtask

    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 8) begin
                E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
            end else begin
                E_icode = 4'h1; E_dstM = 4'hF; d_srcA = 4'hF;
            end
            tick();
        end
        #1;
        n_checks++; if (cycle_count !== (PERF ? 32'd10 : 32'd0)) $display("FAIL perf_cycles got %0d want %0d", cycle_count, PERF ? 10 : 0); else n_pass++;
        n_checks++; if (stall_count !== (PERF ? 32'd3 : 32'd0)) $display("FAIL perf_stalls got %0d want %0d", stall_count, PERF ? 3 : 0); else n_pass++;
    endtask

    function automatic logic [3:0] rand_reg();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    // Reference model: processor mode 0=running, 1=draining, 2=halted.
    task automatic test_random();
        logic [63:0] pred, exp_pc;
        int          mode;
        logic [2:0]  hstat, exp_fstat;
        logic [31:0] cyc, stl;
        logic        lu, rp, mp, fs, db;
        logic [5:0]  exp_ctl;
        int          errs;
        do_reset();
        pred = 64'h0; mode = 0; hstat = 3'd1; cyc = 0; stl = 0; errs = 0;
        for (int n = 0; n < 3000 && errs < 10; n++) begin
            reset      = ($urandom_range(0, (mode == 2) ? 15 : 300) == 0);
            f_icode    = 4'($urandom_range(0, 15));
            imem_error = ($urandom_range(0, 9) == 0);
            f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
            D_icode = 4'($urandom_range(0, 15)); E_icode = 4'($urandom_range(0, 15));
            M_icode = 4'($urandom_range(0, 15)); W_icode = 4'($urandom_range(0, 15));
            d_srcA = rand_reg(); d_srcB = rand_reg(); E_dstM = rand_reg();
            e_Cnd = 1'($urandom); M_Cnd = 1'($urandom);
            M_valA = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
            m_stat = ($urandom_range(0, 20) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            W_stat = ($urandom_range(0, 60) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            #1;
            exp_pc    = (M_icode == 7 && !M_Cnd) ? M_valA : (W_icode == 9) ? W_valM : pred;
            exp_fstat = imem_error ? 3'd3 : (f_icode > 11) ? 3'd4 : (f_icode == 0) ? 3'd2 : 3'd1;
            lu = (E_icode == 5 || E_icode == 11) && E_dstM != 15 && (E_dstM == d_srcA || E_dstM == d_srcB);
            rp = (D_icode == 9 || E_icode == 9 || M_icode == 9);
            mp = (E_icode == 7 && !e_Cnd);
            fs = lu || rp || mode != 0;
            db = (mode != 2) && (mp || (rp && !lu));
            exp_ctl = {fs, lu, db, (mode != 2) && (mp || lu),
                       (m_stat != 1 || W_stat != 1), (W_stat != 1 || mode == 2)};
            n_checks++; if (f_pc !== exp_pc) begin errs++; $display("FAIL rnd_f_pc cyc %0d got %h want %h", n, f_pc, exp_pc); end else n_pass++;
            n_checks++; if (f_stat !== exp_fstat) begin errs++; $display("FAIL rnd_f_stat cyc %0d got %0d want %0d", n, f_stat, exp_fstat); end else n_pass++;
            n_checks++; if (ctl() !== exp_ctl) begin errs++; $display("FAIL rnd_ctl cyc %0d got %b want %b", n, ctl(), exp_ctl); end else n_pass++;
            n_checks++; if ({halted, halt_stat} !== {mode == 2, hstat}) begin errs++; $display("FAIL rnd_halt cyc %0d got %b/%0d want %b/%0d", n, halted, halt_stat, mode == 2, hstat); end else n_pass++;
            n_checks++; if ({cycle_count, stall_count} !== (PERF ? {cyc, stl} : 64'h0)) begin errs++; $display("FAIL rnd_counters cyc %0d got %0d/%0d want %0d/%0d", n, cycle_count, stall_count, PERF ? cyc : 0, PERF ? stl : 0); end else n_pass++;
            if (reset) begin
                pred = 64'h0; mode = 0; hstat = 3'd1; cyc = 0; stl = 0;
            end else begin
                if (mode != 2 && cyc != 32'hFFFF_FFFF) cyc++;
                if (mode == 0 && fs && stl != 32'hFFFF_FFFF) stl++;
                if (!fs) pred = (f_icode == 7 || f_icode == 8) ? f_valC : f_valP;
                if (mode != 2 && W_stat != 1) begin
                    mode = 2; hstat = W_stat;
                end else if (mode == 0 && exp_fstat != 1 && !fs && !db) begin
                    mode = 1;
                end else if (mode == 1 && M_icode == 7 && !M_Cnd) begin
                    mode = 0;
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_jump();
        test_load_use();
        test_ret();
        test_halt();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
